// File: rtl/dmd_pkg.sv
// Shared DMD raster/geometry defaults, derived widths and the dot intensity-to-colour scaling.
package dmd_pkg;

  localparam int DEF_H_DRAW    = 1280;
  localparam int DEF_H_PORCH   = 32;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_FRAME   = 1440;
  localparam int DEF_V_DRAW    = 390;
  localparam int DEF_V_PORCH   = 1;
  localparam int DEF_V_SYNC    = 24;
  localparam int DEF_V_FRAME   = 442;
  localparam int DEF_DOT_PITCH = 10;
  localparam int DEF_DOT_GAP   = 1;
  localparam int DEF_DOTS_X    = 128;
  localparam int DEF_DOTS_Y    = 39;

  localparam int BPP = 4;

  localparam int DOT_XW = $clog2(DEF_DOTS_X);
  localparam int DOT_YW = $clog2(DEF_DOTS_Y);
  localparam int FB_AW  = 1 + DOT_YW + DOT_XW;

  localparam logic [7:0] ON_R  = 8'd255;
  localparam logic [7:0] ON_G  = 8'd132;
  localparam logic [7:0] ON_B  = 8'd9;
  localparam logic [7:0] OFF_R = 8'd50;
  localparam logic [7:0] OFF_G = 8'd50;
  localparam logic [7:0] OFF_B = 8'd50;

  // (on * (L+1)) >> BPP, so the top level reproduces the full-on colour exactly.
  function automatic logic [7:0] scale_chan(input logic [7:0] on, input logic [BPP-1:0] lvl);
    logic [15:0] prod;
    prod = 16'(on) * (16'(lvl) + 16'd1);
    return prod[BPP +: 8];
  endfunction

endpackage

// File: rtl/dmd_dot_counter.sv
// One raster axis: position counter, sub-cell counter and dot index, plus gap/rim flags
// for the current sub-cell position. Cell state clears whenever the raster counter wraps.
module dmd_dot_counter #(
  parameter int FRAME = 1440,
  parameter int PITCH = 10,
  parameter int GAP   = 1,
  parameter int CW    = $clog2(FRAME)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          adv,
  output logic [CW-1:0] cnt,
  output logic [CW-1:0] dot,
  output logic          gap,
  output logic          rim
);

  localparam int SW = $clog2(PITCH);

  logic [SW-1:0] sub;
  logic          wrap;
  logic          sub_wrap;

  assign wrap     = (cnt == CW'(FRAME - 1));
  assign sub_wrap = (sub == SW'(PITCH - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
      sub <= '0;
      dot <= '0;
    end else if (adv) begin
      if (wrap) begin
        cnt <= '0;
        sub <= '0;
        dot <= '0;
      end else begin
        cnt <= cnt + CW'(1);
        if (sub_wrap) begin
          sub <= '0;
          dot <= dot + CW'(1);
        end else begin
          sub <= sub + SW'(1);
        end
      end
    end
  end

  assign gap = (sub < SW'(GAP)) || (sub >= SW'(PITCH - GAP));
  // First or last visible pixel of the cell; used to knock out dot corners.
  assign rim = (sub == SW'(GAP)) || (sub == SW'(PITCH - GAP - 1));

endmodule

// File: rtl/dmd_video_gen.sv
// DMD emulation video generator: raster timing plus a dot grid fed from a banked frame buffer,
// 3-clk counter-to-pixel pipeline. Define DMD_ROUND_DOT_EN to blank the four corners of each dot.
module dmd_video_gen
  import dmd_pkg::*;
#(
  parameter int H_DRAW    = DEF_H_DRAW,
  parameter int H_PORCH   = DEF_H_PORCH,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_FRAME   = DEF_H_FRAME,
  parameter int V_DRAW    = DEF_V_DRAW,
  parameter int V_PORCH   = DEF_V_PORCH,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_FRAME   = DEF_V_FRAME,
  parameter int DOT_PITCH = DEF_DOT_PITCH,
  parameter int DOT_GAP   = DEF_DOT_GAP,
  parameter int DOTS_X    = DEF_DOTS_X,
  parameter int DOTS_Y    = DEF_DOTS_Y,
  localparam int XW  = $clog2(DOTS_X),
  localparam int YW  = $clog2(DOTS_Y),
  localparam int AW  = 1 + YW + XW,
  localparam int HCW = $clog2(H_FRAME),
  localparam int VCW = $clog2(V_FRAME)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           bank_sel,
  output logic [AW-1:0]  fb_addr,
  input  logic [BPP-1:0] fb_data,
  output logic           frame_start,
  output logic           DrawArea,
  output logic           hSync,
  output logic           vSync,
  output logic [7:0]     red,
  output logic [7:0]     green,
  output logic [7:0]     blue
);

`ifdef DMD_ROUND_DOT_EN
  localparam bit ROUND = 1'b1;
`else
  localparam bit ROUND = 1'b0;
`endif

  logic [HCW-1:0] cx, dx;
  logic [VCW-1:0] cy, dy;
  logic           h_gap, h_rim, v_gap, v_rim;
  logic           line_end;

  assign line_end = (cx == HCW'(H_FRAME - 1));

  dmd_dot_counter #(.FRAME(H_FRAME), .PITCH(DOT_PITCH), .GAP(DOT_GAP)) u_hcnt (
    .clk(clk), .reset(reset), .adv(1'b1),
    .cnt(cx), .dot(dx), .gap(h_gap), .rim(h_rim)
  );

  dmd_dot_counter #(.FRAME(V_FRAME), .PITCH(DOT_PITCH), .GAP(DOT_GAP)) u_vcnt (
    .clk(clk), .reset(reset), .adv(line_end),
    .cnt(cy), .dot(dy), .gap(v_gap), .rim(v_rim)
  );

  logic draw0, hs0, vs0, fs0, kill0, blank0, bank_pt;

  assign draw0   = (cx < HCW'(H_DRAW)) && (cy < VCW'(V_DRAW));
  assign hs0     = (cx >= HCW'(H_DRAW + H_PORCH)) && (cx < HCW'(H_DRAW + H_PORCH + H_SYNC));
  assign vs0     = (cy >= VCW'(V_DRAW + V_PORCH)) && (cy < VCW'(V_DRAW + V_PORCH + V_SYNC));
  assign fs0     = (cx == '0) && (cy == '0);
  assign kill0   = h_gap || v_gap || (ROUND && h_rim && v_rim);
  assign blank0  = (dx >= HCW'(DOTS_X)) || (dy >= VCW'(DOTS_Y));
  assign bank_pt = line_end && (cy == VCW'(V_DRAW - 1));

  logic active_bank;
  logic s1_draw, s1_hs, s1_vs, s1_fs, s1_kill, s1_blank;

  // Bank only changes once per frame, after the last visible line, so a frame never tears.
  always_ff @(posedge clk) begin
    if (reset) begin
      active_bank <= 1'b0;
      fb_addr     <= '0;
      s1_draw     <= 1'b0;
      s1_hs       <= 1'b0;
      s1_vs       <= 1'b0;
      s1_fs       <= 1'b0;
      s1_kill     <= 1'b0;
      s1_blank    <= 1'b0;
    end else begin
      if (bank_pt) active_bank <= bank_sel;
      if (!blank0) fb_addr <= {active_bank, dy[YW-1:0], dx[XW-1:0]};
      s1_draw  <= draw0;
      s1_hs    <= hs0;
      s1_vs    <= vs0;
      s1_fs    <= fs0;
      s1_kill  <= kill0;
      s1_blank <= blank0;
    end
  end

  logic [BPP-1:0] s2_level;
  logic           s2_draw, s2_hs, s2_vs, s2_fs, s2_kill, s2_blank;

  always_ff @(posedge clk) begin
    if (reset) begin
      s2_level <= '0;
      s2_draw  <= 1'b0;
      s2_hs    <= 1'b0;
      s2_vs    <= 1'b0;
      s2_fs    <= 1'b0;
      s2_kill  <= 1'b0;
      s2_blank <= 1'b0;
    end else begin
      s2_level <= fb_data;
      s2_draw  <= s1_draw;
      s2_hs    <= s1_hs;
      s2_vs    <= s1_vs;
      s2_fs    <= s1_fs;
      s2_kill  <= s1_kill;
      s2_blank <= s1_blank;
    end
  end

  logic [7:0] pix_r, pix_g, pix_b;

  always_comb begin
    pix_r = '0;
    pix_g = '0;
    pix_b = '0;
    if (s2_draw && !s2_kill && !s2_blank) begin
      if (s2_level == '0) begin
        pix_r = OFF_R;
        pix_g = OFF_G;
        pix_b = OFF_B;
      end else begin
        pix_r = scale_chan(ON_R, s2_level);
        pix_g = scale_chan(ON_G, s2_level);
        pix_b = scale_chan(ON_B, s2_level);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      red         <= '0;
      green       <= '0;
      blue        <= '0;
      DrawArea    <= 1'b0;
      hSync       <= 1'b0;
      vSync       <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      red         <= pix_r;
      green       <= pix_g;
      blue        <= pix_b;
      DrawArea    <= s2_draw;
      hSync       <= s2_hs;
      vSync       <= s2_vs;
      frame_start <= s2_fs;
    end
  end

endmodule

// File: tb/tb_dmd_video_gen.sv
// Randomized bench for dmd_video_gen on a reduced raster, checked against an arithmetic pixel model.
module tb_dmd_video_gen;

  localparam int HD = 40, HP = 4, HS = 6, HF = 56;
  localparam int VD = 30, VP = 1, VS = 3, VF = 36;
  localparam int PITCH = 10, GAP = 1, NDX = 3, NDY = 2;
  localparam int XW = 2, YW = 1, AW = 1 + YW + XW;
  localparam int FR = HF * VF;
  localparam int SP = (VD - 1) * HF + HF - 1;
`ifdef DMD_ROUND_DOT_EN
  localparam bit TB_ROUND = 1'b1;
`else
  localparam bit TB_ROUND = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          bank_sel;
  logic [AW-1:0] fb_addr;
  logic [3:0]    fb_data;
  logic          frame_start, DrawArea, hSync, vSync;
  logic [7:0]    red, green, blue;

  logic [3:0]    mem [0:15];
  bit            samp [0:15];
  logic [AW-1:0] exp_addr;
  int            n, gframe, tog_pos, pos;
  int            n_chk = 0, n_fail = 0;
  bit            did_reset = 0, done = 0;

  always #5 clk = ~clk;
  assign fb_data = mem[fb_addr];

  dmd_video_gen #(
    .H_DRAW(HD), .H_PORCH(HP), .H_SYNC(HS), .H_FRAME(HF),
    .V_DRAW(VD), .V_PORCH(VP), .V_SYNC(VS), .V_FRAME(VF),
    .DOT_PITCH(PITCH), .DOT_GAP(GAP), .DOTS_X(NDX), .DOTS_Y(NDY)
  ) dut (
    .clk(clk), .reset(reset), .bank_sel(bank_sel), .fb_addr(fb_addr), .fb_data(fb_data),
    .frame_start(frame_start), .DrawArea(DrawArea), .hSync(hSync), .vSync(vSync),
    .red(red), .green(green), .blue(blue)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (n=%0d)", tag, got, exp, n);
    end
  endtask

  // Bank used for a read at raster index p: bank_sel as seen at the most recent sample point.
  function automatic bit bank_of(input int p);
    int fr, ps;
    fr = p / FR;
    ps = p % FR;
    if (ps > SP) return samp[fr];
    if (fr == 0) return 1'b0;
    return samp[fr - 1];
  endfunction

  task automatic fill(input int kind);
    for (int i = 0; i < 16; i++)
      case (kind)
        0:       mem[i] = 4'd15;
        1:       mem[i] = 4'd7;
        2:       mem[i] = 4'd0;
        default: mem[i] = 4'($urandom_range(0, 15));
      endcase
  endtask

  task automatic check_zero(input string t);
    check_eq({t, "_addr"},  32'(fb_addr), 0);
    check_eq({t, "_red"},   32'(red), 0);
    check_eq({t, "_green"}, 32'(green), 0);
    check_eq({t, "_blue"},  32'(blue), 0);
    check_eq({t, "_draw"},  32'(DrawArea), 0);
    check_eq({t, "_hs"},    32'(hSync), 0);
    check_eq({t, "_vs"},    32'(vSync), 0);
    check_eq({t, "_fs"},    32'(frame_start), 0);
  endtask

  task automatic check_cycle();
    int  p, q, cx, cy, sx, sy, dx, dy, l, fr;
    bit  draw, hs, vs, fs, dark;
    int  er, eg, eb;
    q  = n - 1;
    cx = q % HF;
    cy = (q / HF) % VF;
    if (cx / PITCH < NDX && cy / PITCH < NDY)
      exp_addr = AW'(int'(bank_of(q)) * (1 << (XW + YW)) + (cy / PITCH) * (1 << XW) + cx / PITCH);
    check_eq("fb_addr", 32'(fb_addr), 32'(exp_addr));
    if (!did_reset && q >= 10 * HF && q < FR) check_eq("bank_hold_msb", 32'(fb_addr[AW-1]), 0);
    if (!did_reset && q == FR) check_eq("bank_next_frame_msb", 32'(fb_addr[AW-1]), 1);

    if (n < 3) begin
      check_zero("fill");
      return;
    end
    p    = n - 3;
    fr   = p / FR;
    cx   = p % HF;
    cy   = (p / HF) % VF;
    draw = cx < HD && cy < VD;
    hs   = cx >= HD + HP && cx < HD + HP + HS;
    vs   = cy >= VD + VP && cy < VD + VP + VS;
    fs   = cx == 0 && cy == 0;
    sx = cx % PITCH; sy = cy % PITCH; dx = cx / PITCH; dy = cy / PITCH;
    dark = !draw || sx < GAP || sx >= PITCH - GAP || sy < GAP || sy >= PITCH - GAP ||
           dx >= NDX || dy >= NDY;
    if (TB_ROUND && (sx == GAP || sx == PITCH - GAP - 1) && (sy == GAP || sy == PITCH - GAP - 1))
      dark = 1;
    er = 0; eg = 0; eb = 0;
    if (!dark) begin
      l = int'(mem[int'(bank_of(p)) * (1 << (XW + YW)) + dy * (1 << XW) + dx]);
      if (l == 0) begin
        er = 50; eg = 50; eb = 50;
      end else begin
        er = (255 * (l + 1)) / 16;
        eg = (132 * (l + 1)) / 16;
        eb = (9 * (l + 1)) / 16;
      end
    end
    check_eq("red", 32'(red), er);
    check_eq("green", 32'(green), eg);
    check_eq("blue", 32'(blue), eb);
    check_eq("DrawArea", 32'(DrawArea), 32'(draw));
    check_eq("hSync", 32'(hSync), 32'(hs));
    check_eq("vSync", 32'(vSync), 32'(vs));
    check_eq("frame_start", 32'(frame_start), 32'(fs));

    // Fixed-colour frames: 15, 7 and 0 everywhere.
    if (!did_reset && fr <= 2 && cy == 5) begin
      if (cx == 5) check_eq("dot_centre_red", 32'(red), fr == 0 ? 255 : (fr == 1 ? 127 : 50));
      if (cx == 5 && fr == 1) check_eq("dot_lvl7_blue", 32'(blue), 4);
      if (cx == 0) check_eq("gap_left_red", 32'(red), 0);
      if (cx == 9) check_eq("gap_right_red", 32'(red), 0);
      if (cx == 35) check_eq("blank_dot_red", 32'(red), 0);
    end
    if (!did_reset && fr == 0 && cy == 1 && cx == 1) check_eq("corner_green", 32'(green), TB_ROUND ? 0 : 132);
    if (!did_reset && fr == 0 && cy == 1 && cx == 2) check_eq("rim_green", 32'(green), 132);
  endtask

  initial begin
    reset    = 1'b1;
    bank_sel = 1'b0;
    fill(0);
    @(posedge clk); #1;
    check_zero("reset");
    reset    = 1'b0;
    n        = 0;
    gframe   = 0;
    tog_pos  = 0;
    exp_addr = '0;
    for (int i = 0; i < 16; i++) samp[i] = 1'b0;

    for (int cyc = 0; cyc < 10 * FR; cyc++) begin
      @(posedge clk); #1;
      n++;
      check_cycle();
      pos = n % FR;
      if (pos == 0) begin
        gframe++;
        tog_pos = $urandom_range(0, FR - 1);
      end
      if (gframe == 7) begin
        done = 1;
        break;
      end
      if (gframe == 0 && pos == 10 * HF) bank_sel = 1'b1;
      if (gframe >= 3 && pos == tog_pos) bank_sel = ~bank_sel;
      if (pos == (VF - 2) * HF) fill(gframe + 1);
      if (gframe == 5 && !did_reset && pos == 10 * HF + 25) begin
        reset = 1'b1;
        @(posedge clk); #1;
        check_zero("midrun_reset");
        reset     = 1'b0;
        did_reset = 1;
        n         = 0;
        exp_addr  = '0;
        for (int i = 0; i < 16; i++) samp[i] = 1'b0;
        continue;
      end
      if (pos == SP) samp[n / FR] = bank_sel;
    end
    if (!done) check_eq("timeout", 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
